uart_tx: RTL and testbench

Buffered UART transmitter. It is the transmit-side counterpart of `uart_rx` and uses the same 8N1 framing and the same 50 MHz / 434-cycle bit time (115200 baud). Bytes arrive over a valid/ready handshake into a small FIFO and are serialised LSB-first on `tx`. `uart_tx.tx` connects directly to `uart_rx.rx` for loopback.

---
 rtl/uart_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, small FIFO, LSB-first serialiser.
`timescale 1ns/1ps

module uart_tx #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      mem [0:FIFO_DEPTH-1];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nxt;

    logic [BW-1:0]   baud_cnt;
    logic [BW-1:0]   baud_nxt;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_nxt;
    logic [7:0]      shift;
    logic [7:0]      shift_nxt;
    logic            tx_nxt;
    logic            push;
    logic            pop;
    logic            baud_end;

    // ready is a register, so a pop in the same cycle cannot re-open it
    assign push     = valid_in && ready;
    assign baud_end = (baud_cnt == BW'(BAUD_DIV - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, serialiser datapath and FIFO pop decision
    always_comb begin
        state_nxt = state;
        tx_nxt    = tx;
        shift_nxt = shift;
        bit_nxt   = bit_idx;
        baud_nxt  = baud_cnt + BW'(1);
        pop       = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                baud_nxt = '0;
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_end) begin
                    tx_nxt    = shift[0];
                    bit_nxt   = '0;
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_idx != 3'd7) begin
                        shift_nxt = {1'b0, shift[7:1]};
                        bit_nxt   = bit_idx + 3'd1;
                        tx_nxt    = shift[1];
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (fifo_count != '0) begin
                        // back-to-back frame: next start bit follows the stop bit directly
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                baud_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase

        count_nxt = fifo_count + CW'(push) - CW'(pop);
    end

    // Datapath, FIFO pointers and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tx         <= 1'b1;
            shift      <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
        end else begin
            tx         <= tx_nxt;
            shift      <= shift_nxt;
            baud_cnt   <= baud_nxt;
            bit_idx    <= bit_nxt;
            fifo_count <= count_nxt;
            ready      <= (count_nxt != CW'(FIFO_DEPTH));
            busy       <= (state_nxt != IDLE) || (count_nxt != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of pushed bytes, line decoder compares frames.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int unsigned BD    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME = 10 * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];
    int         start_q[$];
    int         frames_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive stim_q on consecutive edges with valid_in held high
    task automatic push_burst();
        @(negedge clk);
        for (int i = 0; i < stim_q.size(); i++) begin
            data_in  = stim_q[i];
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(output int fall_cyc);
        bit done;
        done = 1'b0;
        fall_cyc = -1;
        for (int i = 0; i < 8 * FRAME; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) begin
                done = 1'b1;
                fall_cyc = cyc;
                break;
            end
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_count(input logic [2:0] v);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(posedge clk); #1;
            if (fifo_count === v) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("count_timeout", 32'd0, 32'd1);
    endtask

    // Line decoder: finds each falling edge, samples bit centres, checks against the scoreboard
    logic       tx_prev = 1'b1;
    logic [9:0] frame;
    bit         abort;
    int         fstart;
    always begin : line_monitor
        @(posedge clk); #1;
        if (tx_prev === 1'b1 && tx === 1'b0) begin
            abort  = 1'b0;
            fstart = cyc;
            for (int n = 0; n < 10; n++) begin
                repeat ((n == 0) ? BD / 2 : BD) begin
                    @(posedge clk);
                    if (rst) abort = 1'b1;
                end
                #1;
                frame[n] = tx;
            end
            if (!abort) begin
                frames_seen++;
                start_q.push_back(fstart);
                chk("start_bit", 32'(frame[0]), 32'd0);
                chk("stop_bit", 32'(frame[9]), 32'd1);
                if (exp_q.size() == 0) chk("spurious_frame", 32'(frame[8:1]), 32'hFFFF_FFFF);
                else chk("frame_data", 32'(frame[8:1]), 32'(exp_q.pop_front()));
            end
        end
        tx_prev = tx;
    end

    initial begin : watchdog
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int fall;
        int f0;
        int low_cnt;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);

        // Single byte: latency, frame length, busy fall
        start_q.delete();
        f0 = frames_seen;
        @(negedge clk);
        data_in = 8'h41; valid_in = 1'b1; exp_q.push_back(8'h41);
        @(posedge clk); #1;
        chk("t1_tx_accept_edge", 32'(tx), 32'd1);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        chk("t1_count_one", 32'(fifo_count), 32'd1);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk); #1;
        chk("t1_tx_low", 32'(tx), 32'd0);
        chk("t1_count_popped", 32'(fifo_count), 32'd0);
        wait_idle(fall);
        chk("t1_frames", 32'(frames_seen - f0), 32'd1);
        chk("t1_busy_fall", 32'(fall - ((start_q.size() > 0) ? start_q[0] : 0)), 32'(FRAME));

        // Back-to-back: no idle gap, two frames exactly
        start_q.delete();
        f0 = frames_seen;
        stim_q = '{8'h41, 8'h35};
        exp_q.push_back(8'h41); exp_q.push_back(8'h35);
        push_burst();
        wait_idle(fall);
        chk("t2_frames", 32'(frames_seen - f0), 32'd2);
        chk("t2_gap", 32'((start_q.size() > 1) ? start_q[1] - start_q[0] : 0), 32'(FRAME));
        chk("t2_total", 32'(fall - ((start_q.size() > 0) ? start_q[0] : 0)), 32'(2 * FRAME));

        // FIFO full: 0x06 dropped, five frames in order
        f0 = frames_seen;
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        push_burst();
        chk("t3_count_full", 32'(fifo_count), 32'd4);
        chk("t3_ready_low", 32'(ready), 32'd0);
        wait_count(3'd3);
        chk("t3_ready_reopen", 32'(ready), 32'd1);
        wait_idle(fall);
        chk("t3_frames", 32'(frames_seen - f0), 32'd5);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 3 of the first frame
        stim_q = '{8'hA5, 8'h3C};
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        push_burst();
        repeat (4 * BD + BD / 2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        chk("t4_tx", 32'(tx), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_count", 32'(fifo_count), 32'd0);
        chk("t4_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        f0 = frames_seen;
        low_cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) low_cnt++;
        end
        chk("t4_line_quiet", 32'(low_cnt), 32'd0);
        chk("t4_no_frames", 32'(frames_seen - f0), 32'd0);
        stim_q = '{8'h5A};
        exp_q.push_back(8'h5A);
        push_burst();
        wait_idle(fall);
        chk("t4_fresh_frame", 32'(frames_seen - f0), 32'd1);

        // Loopback pattern set
        f0 = frames_seen;
        stim_q = '{8'h41, 8'h35, 8'h00, 8'hFF};
        foreach (stim_q[i]) exp_q.push_back(stim_q[i]);
        push_burst();
        wait_idle(fall);
        chk("t5_frames", 32'(frames_seen - f0), 32'd4);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Push on the exact edge where STOP pops
        f0 = frames_seen;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        @(negedge clk);
        data_in = 8'h11; valid_in = 1'b1;
        @(negedge clk);
        data_in = 8'h22;
        @(negedge clk);
        valid_in = 1'b0;
        chk("t6_count_hold", 32'(fifo_count), 32'd1);
        repeat (FRAME - 1) @(negedge clk);
        chk("t6_stop_bit", 32'(tx), 32'd1);
        data_in = 8'h33; valid_in = 1'b1;
        @(posedge clk); #1;
        chk("t6_count_same", 32'(fifo_count), 32'd1);
        chk("t6_next_start", 32'(tx), 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        wait_idle(fall);
        chk("t6_frames", 32'(frames_seen - f0), 32'd3);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
